// File: rtl/spi_master_mc.sv
// spi_master_mc: SPI master with a 4-word memory-mapped slave port.
// Programmable frame length, CPOL/CPHA, bit order, SCLK divider, chip select and CS hold.
// Optional feature macro SPI_MASTER_IRQ_EN adds the oIrq port and CTRL[11] IRQ_EN.
module spi_master_mc #(
    parameter int DATA_W  = 16,
    parameter int NUM_CS  = 4,
    parameter int DIV_W   = 8,
    parameter int DIV_RST = 4
) (
    input  logic              iClk,
    input  logic              iReset_n,
    input  logic              iChipSelect_n,
    input  logic              iWrite,
    input  logic              iRead,
    input  logic [1:0]        iAddress,
    input  logic [31:0]       iData,
    output logic [31:0]       oData,
    output logic              w_SPI_Clk,
    output logic              w_SPI_MOSI,
    input  logic              w_SPI_MISO,
    output logic [NUM_CS-1:0] w_SPI_NSS
`ifdef SPI_MASTER_IRQ_EN
    ,
    output logic              oIrq
`endif
);

    localparam int         IDX_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [4:0] LEN_MAX = 5'(DATA_W - 1);
`ifdef SPI_MASTER_IRQ_EN
    localparam int         CTRL_W  = 12;
`else
    localparam int         CTRL_W  = 11;
`endif

    typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;
    state_t state, state_nxt;

    // Bus-visible registers
    logic [CTRL_W-1:0] ctrl;
    logic [DIV_W-1:0]  div_r;
    logic [DATA_W-1:0] rx_data;
    logic              rxv, txovr, rxovr;

    // Per-frame shadow copies so CTRL/DIV writes during a frame only affect the next one
    logic              cpha_s, lsb_s, hold_s;
    logic [4:0]        len_s;
    logic [DIV_W-1:0]  div_s;
    logic [DATA_W-1:0] tx_s, rx_sh;

    // Timing: half-period counter, SCLK edge counter, current bit number
    logic [DIV_W-1:0]  cnt;
    logic [5:0]        edge_cnt;
    logic [4:0]        bit_k, bit_k1;

    logic              wr, rd, wr_tx, start, tick, edge_ev, leading, last_edge, frame_done;
    logic [4:0]        len_cl, pos_first, pos_cur, pos_nxt;
    logic [NUM_CS-1:0] nss_dec;
    logic [31:0]       rdata;

    assign wr         = ~iChipSelect_n & iWrite;
    assign rd         = ~iChipSelect_n & iRead & ~iWrite;   // a simultaneous write wins
    assign wr_tx      = wr && (iAddress == 2'd0);
    assign start      = wr_tx && (state == IDLE);
    assign tick       = (cnt == div_s);
    assign edge_ev    = tick && ((state == SETUP) || (state == XFER));
    assign leading    = ~edge_cnt[0];
    assign last_edge  = (edge_cnt == {len_s, 1'b1});
    assign frame_done = tick && (state == HOLD);

    // Frame length is clamped to the shift register width; bit position depends on bit order
    assign len_cl    = (ctrl[7:3] > LEN_MAX) ? LEN_MAX : ctrl[7:3];
    assign pos_first = ctrl[2] ? 5'd0 : len_cl;
    assign bit_k1    = bit_k + 5'd1;
    assign pos_cur   = lsb_s ? bit_k  : len_s - bit_k;
    assign pos_nxt   = lsb_s ? bit_k1 : len_s - bit_k1;

    // One-hot active-low select decode; an out-of-range index selects nothing
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        nss_dec = '1;
        for (int i = 0; i < NUM_CS; i++)
            if (ctrl[9:8] == 2'(i)) nss_dec[i] = 1'b0;
    end

    // State register
    always_ff @(posedge iClk or negedge iReset_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!iReset_n) state <= IDLE;
        else           state <= state_nxt;
    end

    // Next-state logic: SETUP and HOLD last one half-period, XFER ends on the last SCLK edge
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SETUP;
            SETUP:   if (tick) state_nxt = XFER;
            XFER:    if (tick && last_edge) state_nxt = HOLD;
            HOLD:    if (tick) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Serial engine: shadows, divider, SCLK edges, MOSI shifting, MISO sampling, selects
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            cpha_s <= 1'b0; lsb_s <= 1'b0; hold_s <= 1'b0; len_s <= '0; div_s <= '0;
            tx_s <= '0; rx_sh <= '0; cnt <= '0; edge_cnt <= '0; bit_k <= '0;
            w_SPI_Clk <= 1'b0; w_SPI_MOSI <= 1'b0; w_SPI_NSS <= '1;
        end else begin
            cnt <= ((state == IDLE) || tick) ? '0 : cnt + 1'b1;
            if (state == IDLE) w_SPI_Clk <= ctrl[0];
            if (start) begin
                cpha_s <= ctrl[1]; lsb_s <= ctrl[2]; len_s <= len_cl; hold_s <= ctrl[10];
                div_s <= div_r; tx_s <= iData[DATA_W-1:0]; rx_sh <= '0;
                edge_cnt <= '0; bit_k <= '0; w_SPI_NSS <= nss_dec;
                if (!ctrl[1]) w_SPI_MOSI <= iData[pos_first];
            end
            if (edge_ev) begin
                w_SPI_Clk <= ~w_SPI_Clk;
                edge_cnt  <= edge_cnt + 6'd1;
                if (leading) begin
                    if (cpha_s) w_SPI_MOSI <= tx_s[pos_cur[IDX_W-1:0]];
                    else        rx_sh[pos_cur[IDX_W-1:0]] <= w_SPI_MISO;
                end else begin
                    bit_k <= bit_k1;
                    if (cpha_s)         rx_sh[pos_cur[IDX_W-1:0]] <= w_SPI_MISO;
                    else if (!last_edge) w_SPI_MOSI <= tx_s[pos_nxt[IDX_W-1:0]];
                end
            end
            if (frame_done && !hold_s) w_SPI_NSS <= '1;
        end
    end

    // Read mux; unused bits read as zero
    always_comb begin
        rdata = '0;
        case (iAddress)
            2'd0: rdata[DATA_W-1:0] = rx_data;
            2'd1: rdata[CTRL_W-1:0] = ctrl;
            2'd2: rdata[DIV_W-1:0]  = div_r;
            2'd3: rdata[3:0]        = {rxovr, txovr, rxv, (state != IDLE)};
            default: rdata = '0;
        endcase
    end

    // Register file, sticky flags and registered read data
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            ctrl <= '0; div_r <= DIV_W'(DIV_RST); rx_data <= '0;
            rxv <= 1'b0; txovr <= 1'b0; rxovr <= 1'b0; oData <= '0;
        end else begin
            if (wr && iAddress == 2'd1) ctrl  <= iData[CTRL_W-1:0];
            if (wr && iAddress == 2'd2) div_r <= iData[DIV_W-1:0];
            if (rd) oData <= rdata;
            if (frame_done) rx_data <= rx_sh;

            if (frame_done)                        rxv <= 1'b1;   // set beats a same-cycle read
            else if (rd && iAddress == 2'd0)       rxv <= 1'b0;

            if (wr_tx && state != IDLE)            txovr <= 1'b1;
            else if (wr && iAddress == 2'd3 && iData[2]) txovr <= 1'b0;

            if (frame_done && rxv)                 rxovr <= 1'b1;
            else if (wr && iAddress == 2'd3 && iData[3]) rxovr <= 1'b0;
        end
    end

`ifdef SPI_MASTER_IRQ_EN
    // Registered interrupt: enabled OR of the sticky flags
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) oIrq <= 1'b0;
        else           oIrq <= ctrl[11] & (rxv | txovr | rxovr);
    end
`endif

endmodule

// File: tb/tb_spi_master_mc.sv
// tb_spi_master_mc: directed, self-checking bench for spi_master_mc (default parameters).
// Expected RX words go into a scoreboard queue at TX time and are popped on RX reads;
// a passive monitor captures SCLK edges, MOSI bits at sample edges and NSS levels.
module tb_spi_master_mc;

    logic        iClk = 1'b0, iReset_n = 1'b0;
    logic        iChipSelect_n = 1'b1, iWrite = 1'b0, iRead = 1'b0;
    logic [1:0]  iAddress = 2'd0;
    logic [31:0] iData = 32'd0;
    logic [31:0] oData;
    logic        w_SPI_Clk, w_SPI_MOSI, w_SPI_MISO;
    logic [3:0]  w_SPI_NSS;
`ifdef SPI_MASTER_IRQ_EN
    logic        oIrq;
`endif

    logic        miso_loop = 1'b0, miso_val = 1'b0;
    assign w_SPI_MISO = miso_loop ? w_SPI_MOSI : miso_val;

    spi_master_mc dut (
        .iClk(iClk), .iReset_n(iReset_n), .iChipSelect_n(iChipSelect_n),
        .iWrite(iWrite), .iRead(iRead), .iAddress(iAddress), .iData(iData),
        .oData(oData), .w_SPI_Clk(w_SPI_Clk), .w_SPI_MOSI(w_SPI_MOSI),
        .w_SPI_MISO(w_SPI_MISO), .w_SPI_NSS(w_SPI_NSS)
`ifdef SPI_MASTER_IRQ_EN
        , .oIrq(oIrq)
`endif
    );

    always #5 iClk = ~iClk;

    int          total = 0, bad = 0;
    logic [31:0] exp_q[$];
    bit          rx_unread = 1'b0;
    logic        cur_cpol = 1'b0, cur_cpha = 1'b0;

    // Monitor state
    int          mon_edges = 0;
    logic [31:0] mon_bits = 32'd0;
    logic [3:0]  mon_nss_or = 4'd0;
    logic        sclk_prev = 1'b0;
    logic        watch_nss2 = 1'b0, nss2_rose = 1'b0;

    // Passive SPI monitor, sampled on the falling iClk edge
    always @(negedge iClk) begin
        if (w_SPI_Clk !== sclk_prev) begin
            mon_edges++;
            mon_nss_or = mon_nss_or | w_SPI_NSS;
            // Sample point: leading edge for CPHA=0, trailing edge for CPHA=1
            if ((w_SPI_Clk !== cur_cpol) != cur_cpha)
                mon_bits = {mon_bits[30:0], w_SPI_MOSI};
        end
        sclk_prev = w_SPI_Clk;
        if (watch_nss2 && w_SPI_NSS[2] === 1'b1) nss2_rose = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge iClk);
        iChipSelect_n = 1'b0; iWrite = 1'b1; iAddress = a; iData = d;
        @(negedge iClk);
        iChipSelect_n = 1'b1; iWrite = 1'b0;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge iClk);
        iChipSelect_n = 1'b0; iRead = 1'b1; iAddress = a;
        @(negedge iClk);
        d = oData;
        iChipSelect_n = 1'b1; iRead = 1'b0;
    endtask

    task automatic set_ctrl(input logic [31:0] v);
        bus_wr(2'd1, v);
        cur_cpol = v[0];
        cur_cpha = v[1];
        repeat (2) @(negedge iClk);
    endtask

    task automatic clear_mon();
        @(negedge iClk);
        #1;
        mon_edges = 0; mon_bits = 32'd0; mon_nss_or = 4'd0;
    endtask

    // Start a frame and record the RX word the slave side will return
    task automatic start_frame(input logic [31:0] tx, input logic [31:0] exp_rx);
        clear_mon();
        if (rx_unread && exp_q.size() > 0) void'(exp_q.pop_back());   // unread word gets overwritten
        exp_q.push_back(exp_rx);
        bus_wr(2'd0, tx);
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] s;
        int n;
        n = 0;
        do begin
            bus_rd(2'd3, s);
            n++;
        end while (s[0] === 1'b1 && n < 1000);
        check({tag, "_idle"}, 32'(s[0]), 32'd0);
        rx_unread = 1'b1;
    endtask

    task automatic read_rx(input string tag);
        logic [31:0] d, e;
        bus_rd(2'd0, d);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        rx_unread = 1'b0;
        check(tag, d, e);
    endtask

    // MOSI word as the monitor shifts it in (first-sent bit ends up most significant)
    function automatic logic [31:0] exp_mosi(input logic [31:0] tx, input int n, input bit lsb);
        logic [31:0] r;
        r = 32'd0;
        for (int i = 0; i < n; i++)
            if (lsb) r[n-1-i] = tx[i];
            else     r[i]     = tx[i];
        return r;
    endfunction

    initial begin
        logic [31:0] d;

        // Reset state
        repeat (3) @(negedge iClk);
        iReset_n = 1'b1;
        @(negedge iClk);
        check("rst_odata", oData, 32'd0);
        check("rst_sclk", 32'(w_SPI_Clk), 32'd0);
        check("rst_mosi", 32'(w_SPI_MOSI), 32'd0);
        check("rst_nss", 32'(w_SPI_NSS), 32'hF);
        bus_rd(2'd3, d); check("rst_status", d, 32'd0);
        bus_rd(2'd1, d); check("rst_ctrl", d, 32'd0);
        bus_rd(2'd2, d); check("rst_div", d, 32'd4);

        // CTRL write mask
        bus_wr(2'd1, 32'hFFFF_FFFF);
        bus_rd(2'd1, d);
`ifdef SPI_MASTER_IRQ_EN
        check("ctrl_mask", d, 32'hFFF);
`else
        check("ctrl_mask", d, 32'h7FF);
`endif

        // 1: mode 0, LEN=7, DIV=1, CS=0, loopback
        bus_wr(2'd2, 32'd1);
        bus_rd(2'd2, d); check("div_rb", d, 32'd1);
        set_ctrl(32'h38);
        miso_loop = 1'b1;
        start_frame(32'hA5, 32'hA5);
        wait_idle("t1");
        check("t1_edges", 32'(mon_edges), 32'd16);
        check("t1_mosi", mon_bits, exp_mosi(32'hA5, 8, 1'b0));
        check("t1_nss_during", 32'(mon_nss_or), 32'hE);
        check("t1_nss_after", 32'(w_SPI_NSS), 32'hF);
        check("t1_sclk_idle", 32'(w_SPI_Clk), 32'd0);
        bus_rd(2'd3, d); check("t1_status_rxv", d, 32'h2);
        read_rx("t1_rx");
        bus_rd(2'd3, d); check("t1_status_clr", d, 32'h0);

        // 2: mode 3, LSB first, LEN=15, MISO tied high
        set_ctrl(32'h7F);
        miso_loop = 1'b0; miso_val = 1'b1;
        check("t2_sclk_idle_hi", 32'(w_SPI_Clk), 32'd1);
        start_frame(32'h1234, 32'hFFFF);
        wait_idle("t2");
        check("t2_edges", 32'(mon_edges), 32'd32);
        check("t2_mosi_lsb", mon_bits, exp_mosi(32'h1234, 16, 1'b1));
        check("t2_sclk_after", 32'(w_SPI_Clk), 32'd1);
        read_rx("t2_rx");

        // 3: TX write while busy
        set_ctrl(32'h38);
        miso_loop = 1'b1;
        start_frame(32'h5A, 32'h5A);
        bus_wr(2'd0, 32'hFF);
        bus_rd(2'd3, d); check("t3_status_busy", d, 32'h5);
        wait_idle("t3");
        check("t3_mosi", mon_bits, exp_mosi(32'h5A, 8, 1'b0));
        bus_rd(2'd3, d); check("t3_status_done", d, 32'h6);
        bus_wr(2'd3, 32'h4);
        bus_rd(2'd3, d); check("t3_txovr_clr", d, 32'h2);
        read_rx("t3_rx");

        // 4: two frames without an RX read
        start_frame(32'h11, 32'h11);
        wait_idle("t4a");
        start_frame(32'h22, 32'h22);
        wait_idle("t4b");
        bus_rd(2'd3, d); check("t4_status_ovr", d, 32'hA);
        read_rx("t4_rx");
        bus_wr(2'd3, 32'h8);
        bus_rd(2'd3, d); check("t4_rxovr_clr", d, 32'h0);

        // 5: CS_HOLD on CS 2 across two frames, then release
        set_ctrl(32'h638);
        start_frame(32'h3C, 32'h3C);
        wait_idle("t5a");
        check("t5_nss_hold1", 32'(w_SPI_NSS), 32'hB);
        watch_nss2 = 1'b1; nss2_rose = 1'b0;
        read_rx("t5_rx1");
        start_frame(32'hC3, 32'hC3);
        wait_idle("t5b");
        repeat (3) @(negedge iClk);
        watch_nss2 = 1'b0;
        check("t5_nss2_held", 32'(nss2_rose), 32'd0);
        check("t5_nss_during", 32'(mon_nss_or), 32'hB);
        read_rx("t5_rx2");
        set_ctrl(32'h238);
        start_frame(32'h96, 32'h96);
        wait_idle("t5c");
        check("t5_nss_release", 32'(w_SPI_NSS), 32'hF);
        read_rx("t5_rx3");

        // 6: reset in the middle of bit 3
        set_ctrl(32'h38);
        start_frame(32'h3C, 32'h3C);
        for (int i = 0; i < 400 && mon_edges < 6; i++) @(negedge iClk);
        check("t6_reach_bit3", 32'(mon_edges >= 6), 32'd1);
        iReset_n = 1'b0;
        #1;
        check("t6_nss_rst", 32'(w_SPI_NSS), 32'hF);
        check("t6_sclk_rst", 32'(w_SPI_Clk), 32'd0);
        check("t6_mosi_rst", 32'(w_SPI_MOSI), 32'd0);
        exp_q.delete();
        rx_unread = 1'b0;
        cur_cpol = 1'b0; cur_cpha = 1'b0;
        repeat (2) @(negedge iClk);
        iReset_n = 1'b1;
        bus_rd(2'd3, d); check("t6_status", d, 32'h0);
        bus_rd(2'd2, d); check("t6_div", d, 32'd4);

`ifdef SPI_MASTER_IRQ_EN
        // Interrupt follows RXV when enabled
        set_ctrl(32'h838);
        start_frame(32'h77, 32'h77);
        wait_idle("irq");
        repeat (2) @(negedge iClk);
        check("irq_set", 32'(oIrq), 32'd1);
        read_rx("irq_rx");
        repeat (2) @(negedge iClk);
        check("irq_clr", 32'(oIrq), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
